// File: rtl/dmem_responder.sv
// Word-organised data memory slave with a fixed number of wait states and a held response.
// Optional build macro DMEM_MISALIGN_ERR_EN flags accesses whose addr[1:0] is non-zero.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic             lat_we;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [3:0]       lat_be;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;
    logic             cur_we;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [3:0]       cur_be;
    logic [IDX_W-1:0] cur_idx;
    logic             misalign;
    logic             commit_wr;
    logic [31:0]      rdata_q;
    logic             unused_addr_bits;

    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == RESP);
    assign rsp_rdata  = rdata_q;
    assign accept     = req_valid && (state == IDLE);
    assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd1));

    // With zero wait states RESP is entered on the accept edge, before the latches hold the request
    always_comb begin
        cur_we    = lat_we;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        cur_be    = lat_be;
        if (state == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end
    end

    assign cur_idx          = cur_addr[IDX_W+1:2];
    assign unused_addr_bits = ^{cur_addr[31:IDX_W+2], cur_addr[1:0]};

`ifdef DMEM_MISALIGN_ERR_EN
    logic err_q;
    assign misalign = (cur_addr[1:0] != 2'b00);
    assign rsp_err  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (enter_resp) begin
            err_q <= misalign;
        end
    end
`else
    assign misalign = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    // rst_n gate keeps a store from committing on an edge seen while reset is held
    assign commit_wr = enter_resp && cur_we && !misalign && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                rdata_q <= (cur_we || misalign) ? 32'd0 : mem[cur_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    // Storage is never reset so its contents survive an aborted transaction
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed-vector bench for dmem_responder: table of transactions plus reset/handshake sequences.
module tb_dmem_responder;

    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int nvec = 0;
    int nerr = 0;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAITC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

`ifdef DMEM_MISALIGN_ERR_EN
    localparam logic MIS = 1'b1;
`else
    localparam logic MIS = 1'b0;
`endif

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input int hold, input logic [31:0] er,
                                input logic ee);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.hold = hold; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic txn(input vec_t v, output logic [31:0] rd, output logic er, output int lat,
                       output logic stable, output logic idle_after);
        int g;
        req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
        req_valid = 1'b1; rsp_ready = 1'b0;
        g = 0;
        while (!req_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata; er = rsp_err; stable = 1'b1;
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            if (rsp_rdata !== rd || rsp_err !== er || rsp_valid !== 1'b1 || req_ready !== 1'b0)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        idle_after = req_ready && !rsp_valid;
    endtask

    task automatic run_one(input string nm, input vec_t v);
        logic [31:0] rd;
        logic        er, stable, idle_after;
        int          lat;
        txn(v, rd, er, lat, stable, idle_after);
        chk({nm, "_lat"}, 32'(lat), 32'(WAITC + 1));
        chk({nm, "_rdata"}, rd, v.exp_rdata);
        chk({nm, "_err"}, 32'(er), 32'(v.exp_err));
        if (v.hold > 0) chk({nm, "_stable"}, 32'(stable), 32'd1);
        chk({nm, "_idle"}, 32'(idle_after), 32'd1);
    endtask

    initial begin
        int g;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; rsp_ready = 1'b0;

        vecs.push_back(mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0));
        vecs.push_back(mk(0, 32'h10, 32'h0, 4'hF, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0, 0));
        vecs.push_back(mk(1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 32'h0, 0));
        vecs.push_back(mk(0, 32'h20, 32'h0, 4'hF, 0, 32'h11BB33DD, 0));
        vecs.push_back(mk(1, 32'h24, 32'h11223344, 4'hF, 0, 32'h0, 0));
        vecs.push_back(mk(1, 32'h24, 32'hAABBCCDD, 4'b0100, 0, 32'h0, 0));
        vecs.push_back(mk(0, 32'h24, 32'h0, 4'hF, 5, 32'h11BB3344, 0));
        vecs.push_back(mk(1, 32'h400, 32'h5A5A5A5A, 4'hF, 0, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0, 32'h0, 4'h0, 0, 32'h5A5A5A5A, 0));
        vecs.push_back(mk(1, 32'h10, 32'hFFFFFFFF, 4'h0, 2, 32'h0, 0));
        vecs.push_back(mk(0, 32'hFFFFFC10, 32'h0, 4'hF, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 32'h30, 32'h01020304, 4'hF, 0, 32'h0, 0));
        vecs.push_back(mk(1, 32'h50, 32'h00000000, 4'hF, 0, 32'h0, 0));
        vecs.push_back(mk(1, 32'h13, 32'h12345678, 4'hF, 0, 32'h0, MIS));
        vecs.push_back(mk(0, 32'h10, 32'h0, 4'hF, 0, MIS ? 32'hDEADBEEF : 32'h12345678, 0));
        vecs.push_back(mk(0, 32'h11, 32'h0, 4'hF, 0, MIS ? 32'h0 : 32'h12345678, MIS));

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        foreach (vecs[i]) run_one($sformatf("vec%0d", i), vecs[i]);

        // Reset during WAIT aborts an uncommitted store
        req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF; req_be = 4'hF; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wrst_in_wait", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("wrst_ready_async", 32'(req_ready), 32'd1);
        chk("wrst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_one("wrst_load", mk(0, 32'h30, 32'h0, 4'hF, 0, 32'h01020304, 0));

        // Reset while a response is being held drops it at once
        req_we = 1'b0; req_addr = 32'h24; req_be = 4'hF; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        g = 0;
        while (!rsp_valid && g < 40) begin @(negedge clk); g++; end
        chk("rrst_pre_valid", 32'(rsp_valid), 32'd1);
        chk("rrst_pre_rdata", rsp_rdata, 32'h11BB3344);
        rst_n = 1'b0;
        #1;
        chk("rrst_valid_async", 32'(rsp_valid), 32'd0);
        chk("rrst_rdata_async", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rrst_ready", 32'(req_ready), 32'd1);

        // Request activity while busy is ignored; no re-accept on the completing edge
        req_we = 1'b0; req_addr = 32'h20; req_be = 4'hF; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h50; req_wdata = 32'hBAD0BAD0;
        g = 0;
        while (!rsp_valid && g < 40) begin
            req_valid = ~req_valid;
            @(negedge clk);
            g++;
        end
        chk("busy_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("busy_rdata", rsp_rdata, 32'h11BB33DD);
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("gap_ready", 32'(req_ready), 32'd1);
        chk("gap_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("gap_accepted", 32'(req_ready), 32'd0);
        g = 0;
        while (!rsp_valid && g < 40) begin @(negedge clk); g++; end
        chk("gap_store_rdata", rsp_rdata, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        run_one("gap_load", mk(0, 32'h50, 32'h0, 4'hF, 0, 32'hBAD0BAD0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
